// File: rtl/adc_readout_pkg.sv
// Shared state encoding and sizing helpers for the dual SAR ADC readout.
package adc_readout_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        WAIT_BUSY,
        SHIFT,
        DONE,
        HOLD
    } state_t;

    localparam int unsigned DATA_W_DEF  = 24;
    localparam int unsigned FRAME_CNT_W = 16;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/adc_shift_lane.sv
// One ADC lane: busy synchroniser, MSB-first capture shift register and held sample.
module adc_shift_lane
    import adc_readout_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              busy,
    input  logic              sdoa,
    input  logic              shift_en,
    input  logic              load,
    output logic              busy_s,
    output logic [DATA_W-1:0] sample
);

    logic [1:0]        busy_sync;
    logic [DATA_W-1:0] shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_sync <= '0;
            shreg     <= '0;
            sample    <= '0;
        end else begin
            busy_sync <= {busy_sync[0], busy};
            if (shift_en) shreg  <= {shreg[DATA_W-2:0], sdoa};
            if (load)     sample <= shreg;
        end
    end

    assign busy_s = busy_sync[1];

endmodule

// File: rtl/adc_dual_readout.sv
// Frame-rate conversion/readout controller driving two SAR ADCs (I and Q) in lockstep.
module adc_dual_readout
    import adc_readout_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned CONV_PERIOD  = 100,
    parameter int unsigned MCLK_HIGH    = 2,
    parameter int unsigned BUSY_MIN     = 2,
    parameter int unsigned BUSY_TIMEOUT = 30
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   busy_i,
    input  logic                   busy_q,
    input  logic                   sdoa_i,
    input  logic                   sdoa_q,
    output logic                   mclk_i,
    output logic                   mclk_q,
    output logic                   scka_i,
    output logic                   scka_q,
    output logic                   sample_valid,
    output logic [DATA_W-1:0]      sample_i,
    output logic [DATA_W-1:0]      sample_q,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   timeout_err,
    output logic                   overrun_err
);

    localparam int unsigned SHIFT_LEN = 2 * DATA_W;
    localparam int unsigned STEP_A    = (SHIFT_LEN > BUSY_TIMEOUT) ? SHIFT_LEN : BUSY_TIMEOUT;
    localparam int unsigned STEP_MAX  = (STEP_A > MCLK_HIGH) ? STEP_A : MCLK_HIGH;
    localparam int unsigned PCNT_W    = cnt_width(CONV_PERIOD - 1);
    localparam int unsigned STEP_W    = cnt_width(STEP_MAX);

    state_t            state, state_n;
    logic [PCNT_W-1:0] pcnt;
    logic [STEP_W-1:0] step;
    logic              mclk_r, scka_r;
    logic              mclk_n, scka_n;
    logic              tc, busy_any, shift_en, load, timeout_hit;
    logic              busy_s_i, busy_s_q;

    assign tc       = (pcnt == PCNT_W'(CONV_PERIOD - 1));
    assign busy_any = busy_s_i | busy_s_q;

    always_comb begin
        state_n     = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE:      if (en) state_n = CONV;
            CONV:      if (step == STEP_W'(MCLK_HIGH - 1)) state_n = WAIT_BUSY;
            WAIT_BUSY: begin
                if ((step >= STEP_W'(BUSY_MIN)) && !busy_any) begin
                    state_n = SHIFT;
                end else if (step == STEP_W'(BUSY_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_n     = HOLD;
                end
            end
            SHIFT:     if (step == STEP_W'(SHIFT_LEN - 1)) state_n = DONE;
            DONE:      state_n = HOLD;
            HOLD:      if (tc) state_n = en ? CONV : IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // scka starts high on SHIFT entry and toggles; data is captured on each 0->1 edge.
    assign mclk_n   = (state_n == CONV);
    assign scka_n   = (state_n == SHIFT) && ((state != SHIFT) || !scka_r);
    assign shift_en = scka_n && !scka_r;
    assign load     = (state_n == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pcnt         <= '0;
            step         <= '0;
            mclk_r       <= 1'b0;
            scka_r       <= 1'b0;
            sample_valid <= 1'b0;
            frame_cnt    <= '0;
            timeout_err  <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            state        <= state_n;
            pcnt         <= ((state == IDLE) || tc) ? '0 : pcnt + 1'b1;
            step         <= (state_n != state) ? '0 : step + 1'b1;
            mclk_r       <= mclk_n;
            scka_r       <= scka_n;
            sample_valid <= load;
            if (load) frame_cnt <= frame_cnt + 1'b1;
            if (timeout_hit) timeout_err <= 1'b1;
            // A TC missed while still converting/reading means the next frame slot is skipped.
            if (tc && (state inside {CONV, WAIT_BUSY, SHIFT})) overrun_err <= 1'b1;
        end
    end

    assign mclk_i = mclk_r;
    assign mclk_q = mclk_r;
    assign scka_i = scka_r;
    assign scka_q = scka_r;

    adc_shift_lane #(.DATA_W(DATA_W)) u_lane_i (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy_i),
        .sdoa     (sdoa_i),
        .shift_en (shift_en),
        .load     (load),
        .busy_s   (busy_s_i),
        .sample   (sample_i)
    );

    adc_shift_lane #(.DATA_W(DATA_W)) u_lane_q (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy_q),
        .sdoa     (sdoa_q),
        .shift_en (shift_en),
        .load     (load),
        .busy_s   (busy_s_q),
        .sample   (sample_q)
    );

endmodule

// File: tb/tb_adc_dual_readout.sv
// Directed bench for adc_dual_readout: frame vectors plus reset, enable, wrap and overrun sequences.
`timescale 1ns/1ps
module tb_adc_dual_readout;
    import adc_readout_pkg::*;

    typedef struct {
        logic [23:0] pi;
        logic [23:0] pq;
        int          hold_i;
        int          hold_q;
        int          drop_en_at;
        logic        exp_valid;
        int          exp_lat;
        logic [23:0] exp_si;
        logic [23:0] exp_sq;
        logic [15:0] exp_fc;
        int          exp_to_k;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, en;
    logic        busy_i, busy_q;
    logic [23:0] sh_i, sh_q, pat_i, pat_q;
    int          hold_i, hold_q;
    logic        mclk_i, mclk_q, scka_i, scka_q, sample_valid, timeout_err, overrun_err;
    logic [23:0] sample_i, sample_q;
    logic [15:0] frame_cnt;

    logic        mclk_i2, mclk_q2, scka_i2, scka_q2, sample_valid2, timeout_err2, overrun_err2;
    logic [23:0] sample_i2, sample_q2;
    logic [15:0] frame_cnt2;

    logic        mclk_d, scka_d, to_d, scka2_d;
    int          n_cmp = 0;
    int          n_err = 0;
    vec_t        vecs[7];
    vec_t        wrap_v;

    always #20 clk = ~clk;

    adc_dual_readout dut (
        .clk(clk), .rst(rst), .en(en), .busy_i(busy_i), .busy_q(busy_q),
        .sdoa_i(sh_i[23]), .sdoa_q(sh_q[23]), .mclk_i(mclk_i), .mclk_q(mclk_q),
        .scka_i(scka_i), .scka_q(scka_q), .sample_valid(sample_valid),
        .sample_i(sample_i), .sample_q(sample_q), .frame_cnt(frame_cnt),
        .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    adc_dual_readout #(.CONV_PERIOD(50)) dut2 (
        .clk(clk), .rst(rst), .en(1'b1), .busy_i(1'b0), .busy_q(1'b0),
        .sdoa_i(1'b1), .sdoa_q(1'b0), .mclk_i(mclk_i2), .mclk_q(mclk_q2),
        .scka_i(scka_i2), .scka_q(scka_q2), .sample_valid(sample_valid2),
        .sample_i(sample_i2), .sample_q(sample_q2), .frame_cnt(frame_cnt2),
        .timeout_err(timeout_err2), .overrun_err(overrun_err2)
    );

    always @(posedge clk) begin
        mclk_d  <= mclk_i;
        scka_d  <= scka_i;
        to_d    <= timeout_err;
        scka2_d <= scka_i2;
    end

    // ADC model: busy rises with mclk, falls hold cycles after mclk falls; sdo updates after scka rises.
    initial begin : adc_model
        int  cnt_i, cnt_q;
        logic mprev, sprev;
        busy_i = 1'b0; busy_q = 1'b0; sh_i = '0; sh_q = '0;
        cnt_i = 0; cnt_q = 0; mprev = 1'b0; sprev = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (cnt_i > 0) begin cnt_i--; if (cnt_i == 0) busy_i = 1'b0; end
            if (cnt_q > 0) begin cnt_q--; if (cnt_q == 0) busy_q = 1'b0; end
            if (mclk_i && !mprev) begin
                busy_i = 1'b1; busy_q = 1'b1; sh_i = pat_i; sh_q = pat_q;
            end
            if (!mclk_i && mprev) begin
                cnt_i = hold_i; cnt_q = hold_q;
                if (hold_i == 0) busy_i = 1'b0;
                if (hold_q == 0) busy_q = 1'b0;
            end
            if (scka_i && !sprev) begin
                sh_i = {sh_i[22:0], 1'b0};
                sh_q = {sh_q[22:0], 1'b0};
            end
            mprev = mclk_i; sprev = scka_i;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int   waited, pulses, nval, lat, to_k, lane_diff;
        logic found;
        pat_i = v.pi; pat_q = v.pq; hold_i = v.hold_i; hold_q = v.hold_q;
        waited = 0; found = 1'b0;
        while (!found && waited < 300) begin
            @(negedge clk);
            waited++;
            if (mclk_i && !mclk_d) found = 1'b1;
        end
        check("frame_start_gap", waited, 1);
        check("pcnt_at_start", 32'(dut.pcnt), 0);
        pulses = 0; nval = 0; lat = -1; to_k = -1; lane_diff = 0;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) @(negedge clk);
            if (k == v.drop_en_at) en = 1'b0;
            if (scka_i && !scka_d) pulses++;
            if (sample_valid) begin nval++; lat = k; end
            if (timeout_err && !to_d) to_k = k;
            if ((mclk_q !== mclk_i) || (scka_q !== scka_i)) lane_diff++;
        end
        check("strobe_count", nval, v.exp_valid ? 1 : 0);
        if (v.exp_valid) check("strobe_latency", lat, v.exp_lat);
        check("scka_pulses", pulses, v.exp_valid ? 24 : 0);
        check("sample_i", sample_i, v.exp_si);
        check("sample_q", sample_q, v.exp_sq);
        check("frame_cnt", frame_cnt, v.exp_fc);
        check("timeout_rise_cycle", to_k, v.exp_to_k);
        check("overrun_err", overrun_err, 0);
        check("lane_outputs_equal", lane_diff, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int   cnt, found_cnt, t1, p2;
        logic [15:0] fc1;
        logic found;
        vecs[0] = '{24'hA5C3F1, 24'h123456, 15, 15, -1, 1'b1, 68, 24'hA5C3F1, 24'h123456, 16'd1, -1};
        vecs[1] = '{24'h800001, 24'h7FFFFE, 15, 15, -1, 1'b1, 68, 24'h800001, 24'h7FFFFE, 16'd2, -1};
        vecs[2] = '{24'h000000, 24'hFFFFFF,  0,  0, -1, 1'b1, 53, 24'h000000, 24'hFFFFFF, 16'd3, -1};
        vecs[3] = '{24'h3C3C3C, 24'hC3C3C3,  0, 20, -1, 1'b1, 73, 24'h3C3C3C, 24'hC3C3C3, 16'd4, -1};
        vecs[4] = '{24'h111111, 24'h222222, 15, 38, -1, 1'b0,  0, 24'h3C3C3C, 24'hC3C3C3, 16'd4, 32};
        vecs[5] = '{24'h5A5A5A, 24'h0F0F0F, 15, 15, -1, 1'b1, 68, 24'h5A5A5A, 24'h0F0F0F, 16'd5, -1};
        vecs[6] = '{24'h654321, 24'hFEDCBA, 15, 15, 30, 1'b1, 68, 24'h654321, 24'hFEDCBA, 16'd6, -1};
        wrap_v  = '{24'h0F1E2D, 24'h7C8B9A, 15, 15, -1, 1'b1, 68, 24'h0F1E2D, 24'h7C8B9A, 16'h0000, -1};

        rst = 1'b1; en = 1'b0; pat_i = '0; pat_q = '0; hold_i = 15; hold_q = 15;
        repeat (3) @(negedge clk);
        check("rst_mclk", mclk_i, 0);
        check("rst_scka", scka_i, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_sample_i", sample_i, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_errors", {timeout_err, overrun_err}, 0);
        check("rst_state", dut.state, IDLE);

        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 7; i++) run_frame(vecs[i]);

        // en was dropped mid-frame in the last vector: controller must park in IDLE.
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (mclk_i) cnt++;
        end
        check("idle_no_mclk", cnt, 0);
        check("idle_state", dut.state, IDLE);

        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        en = 1'b1;
        run_frame(wrap_v);

        // Reset during bit 10 of SHIFT (high phase at frame cycle 40).
        found = 1'b0; found_cnt = 0;
        while (!found && found_cnt < 300) begin
            @(negedge clk); found_cnt++;
            if (mclk_i && !mclk_d) found = 1'b1;
        end
        check("rst_seq_frame_start", found, 1);
        repeat (40) @(negedge clk);
        check("rst_seq_scka_high", scka_i, 1);
        rst = 1'b1; en = 1'b0;
        @(negedge clk);
        check("midrst_mclk", {mclk_i, mclk_q}, 0);
        check("midrst_scka", {scka_i, scka_q}, 0);
        check("midrst_valid", sample_valid, 0);
        check("midrst_sample_i", sample_i, 0);
        check("midrst_sample_q", sample_q, 0);
        check("midrst_frame_cnt", frame_cnt, 0);
        check("midrst_errors", {timeout_err, overrun_err}, 0);
        check("midrst_state", dut.state, IDLE);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sample_valid || mclk_i) cnt++;
        end
        check("postrst_quiet", cnt, 0);

        // Short-period instance: overrun, strobes every 100 cycles.
        found = 1'b0; found_cnt = 0;
        while (!found && found_cnt < 300) begin
            @(negedge clk); found_cnt++;
            if (sample_valid2) found = 1'b1;
        end
        check("ovr_first_strobe", found, 1);
        t1 = found_cnt; fc1 = frame_cnt2 + 16'd1;
        found = 1'b0; p2 = 0;
        while (!found && found_cnt < 600) begin
            @(negedge clk); found_cnt++;
            if (scka_i2 && !scka2_d) p2++;
            if ((mclk_q2 !== mclk_i2) || (scka_q2 !== scka_i2)) p2 += 1000;
            if (sample_valid2) found = 1'b1;
        end
        check("ovr_strobe_spacing", found_cnt - t1, 100);
        check("ovr_scka_pulses", p2, 24);
        check("ovr_frame_cnt", frame_cnt2, fc1);
        check("ovr_sample_i", sample_i2, 24'hFFFFFF);
        check("ovr_sample_q", sample_q2, 24'h000000);
        check("ovr_overrun_err", overrun_err2, 1);
        check("ovr_timeout_err", timeout_err2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
